// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retired-instruction records into a show-ahead
// FIFO, drains them over valid/ready, and signals done once halt has drained.
`ifndef DATA_MEM_DEPTH
`define DATA_MEM_DEPTH 10
`endif

module commit_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int DMEM_AW = `DATA_MEM_DEPTH,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit,
  input  logic               commit_halt,
  input  logic [31:0]        commit_pc,
  input  logic [31:0]        commit_instr,
  input  logic               commit_reg_we,
  input  logic [4:0]         commit_reg_wa,
  input  logic [31:0]        commit_reg_wd,
  input  logic               commit_dmem_we,
  input  logic [DMEM_AW-1:0] commit_dmem_wa,
  input  logic [31:0]        commit_dmem_wd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  output logic               out_reg_we,
  output logic [4:0]         out_reg_wa,
  output logic [31:0]        out_reg_wd,
  output logic               out_dmem_we,
  output logic [DMEM_AW-1:0] out_dmem_wa,
  output logic [31:0]        out_dmem_wd,
  output logic               out_halt,
  output logic [CNT_W-1:0]   commit_cnt,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               overflow,
  output logic               done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic               reg_we;
    logic [4:0]         reg_wa;
    logic [31:0]        reg_wd;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_wa;
    logic [31:0]        dmem_wd;
    logic               halt;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             wr_rec;
  rec_t             head;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ, occ_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, push, pop, drop, in_run;

  assign occ    = wr_ptr_q - rd_ptr_q;
  assign full   = (occ == FULL_OCC);
  assign empty  = (occ == '0);
  assign in_run = (state_q == ST_RUN);
  assign pop    = !empty && out_ready;
  assign push   = commit && in_run && (!full || pop);
  assign drop   = commit && in_run && full && !pop;

  assign wr_rec = '{pc: commit_pc, instr: commit_instr, reg_we: commit_reg_we,
                    reg_wa: commit_reg_wa, reg_wd: commit_reg_wd,
                    dmem_we: commit_dmem_we, dmem_wa: commit_dmem_wa,
                    dmem_wd: commit_dmem_wd, halt: commit_halt};

  always_comb begin
    wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop};
    occ_d        = wr_ptr_d - rd_ptr_d;
    commit_cnt_d = commit_cnt_q + {{(CNT_W-1){1'b0}}, push};
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q || drop;
    cycle_cnt_d  = cycle_cnt_q;
    state_d      = state_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if ((state_q != ST_DONE) && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    case (state_q)
      ST_RUN:   if (commit && commit_halt) state_d = ST_DRAIN;
      ST_DRAIN: if (occ_d == '0) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ST_RUN;
      commit_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      commit_cnt_q <= commit_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: record storage has no reset; stale entries are unreachable because
  // out_valid depends only on the reset pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
  end

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid   = !empty;
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_reg_we  = head.reg_we;
  assign out_reg_wa  = head.reg_wa;
  assign out_reg_wd  = head.reg_wd;
  assign out_dmem_we = head.dmem_we;
  assign out_dmem_wa = head.dmem_wa;
  assign out_dmem_wd = head.dmem_wd;
  assign out_halt    = head.halt;
  assign commit_cnt  = commit_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign overflow    = overflow_q;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: ordering, overflow, full push+pop,
// halt drain/done, asynchronous reset and show-ahead stability.
module tb_commit_trace_buffer;

  localparam int DMEM_AW = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               commit, commit_halt;
  logic [31:0]        commit_pc, commit_instr;
  logic               commit_reg_we;
  logic [4:0]         commit_reg_wa;
  logic [31:0]        commit_reg_wd;
  logic               commit_dmem_we;
  logic [DMEM_AW-1:0] commit_dmem_wa;
  logic [31:0]        commit_dmem_wd;
  logic               out_valid, out_ready;
  logic [31:0]        out_pc, out_instr;
  logic               out_reg_we;
  logic [4:0]         out_reg_wa;
  logic [31:0]        out_reg_wd;
  logic               out_dmem_we;
  logic [DMEM_AW-1:0] out_dmem_wa;
  logic [31:0]        out_dmem_wd;
  logic               out_halt;
  logic [31:0]        commit_cnt, cycle_cnt, drop_cnt;
  logic               overflow, done;

  int tests = 0;
  int fails = 0;
  int ticks = 0;
  int ticks_at_done;

  commit_trace_buffer #(.DEPTH(16), .DMEM_AW(DMEM_AW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .commit(commit), .commit_halt(commit_halt),
    .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa),
    .commit_reg_wd(commit_reg_wd), .commit_dmem_we(commit_dmem_we),
    .commit_dmem_wa(commit_dmem_wa), .commit_dmem_wd(commit_dmem_wd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_reg_we(out_reg_we), .out_reg_wa(out_reg_wa), .out_reg_wd(out_reg_wd),
    .out_dmem_we(out_dmem_we), .out_dmem_wa(out_dmem_wa), .out_dmem_wd(out_dmem_wd),
    .out_halt(out_halt),
    .commit_cnt(commit_cnt), .cycle_cnt(cycle_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    ticks++;
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic halt);
    commit         = 1'b1;
    commit_halt    = halt;
    commit_pc      = pc;
    commit_instr   = ~pc;
    commit_reg_we  = pc[2];
    commit_reg_wa  = pc[6:2];
    commit_reg_wd  = pc + 32'h11;
    commit_dmem_we = pc[3];
    commit_dmem_wa = pc[11:2];
    commit_dmem_wd = pc ^ 32'h5a5a_5a5a;
  endtask

  task automatic idle();
    commit      = 1'b0;
    commit_halt = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    set_commit(32'h0, 1'b0);
    idle();
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_commit_cnt", commit_cnt, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_drop_cnt", drop_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ticks = 0;

    // 1: three back-to-back commits streamed straight through
    out_ready = 1'b1;
    set_commit(32'h1c00_0000, 1'b0);
    check("t1_valid_before", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid0", 32'(out_valid), 32'd1);
    check("t1_pc0", out_pc, 32'h1c00_0000);
    check("t1_instr0", out_instr, 32'he3ff_ffff);
    check("t1_reg_wd0", out_reg_wd, 32'h1c00_0011);
    check("t1_dmem_wd0", out_dmem_wd, 32'h465a_5a5a);
    set_commit(32'h1c00_0004, 1'b0);
    tick();
    check("t1_pc1", out_pc, 32'h1c00_0004);
    check("t1_reg_we1", 32'(out_reg_we), 32'd1);
    check("t1_reg_wa1", 32'(out_reg_wa), 32'd1);
    set_commit(32'h1c00_0008, 1'b0);
    tick();
    check("t1_pc2", out_pc, 32'h1c00_0008);
    check("t1_dmem_we2", 32'(out_dmem_we), 32'd1);
    check("t1_dmem_wa2", 32'(out_dmem_wa), 32'd2);
    idle();
    tick();
    check("t1_empty", 32'(out_valid), 32'd0);
    check("t1_commit_cnt", commit_cnt, 32'd3);
    check("t1_drop_cnt", drop_cnt, 32'd0);
    check("t1_cycle_cnt", cycle_cnt, 32'(ticks));

    // 2: 18 commits with the consumer stalled; two are dropped
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      set_commit(32'h1c00_1000 + 32'(4 * i), 1'b0);
      tick();
    end
    idle();
    check("t2_commit_cnt", commit_cnt, 32'd19);
    check("t2_drop_cnt", drop_cnt, 32'd2);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_head_pc", out_pc, 32'h1c00_1000);

    // 3: push and pop on a full FIFO in the same cycle
    out_ready = 1'b1;
    set_commit(32'h1c00_2000, 1'b0);
    tick();
    idle();
    check("t3_drop_cnt", drop_cnt, 32'd2);
    check("t3_commit_cnt", commit_cnt, 32'd20);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("t3_pc%0d", i), out_pc, 32'h1c00_1004 + 32'(4 * i));
      check($sformatf("t3_valid%0d", i), 32'(out_valid), 32'd1);
      tick();
    end
    check("t3_last_pc", out_pc, 32'h1c00_2000);
    check("t3_last_valid", 32'(out_valid), 32'd1);
    tick();
    check("t3_drained", 32'(out_valid), 32'd0);

    // 4: halt behind two older entries, trailing commits ignored
    out_ready = 1'b0;
    set_commit(32'h1c00_0038, 1'b0);
    tick();
    set_commit(32'h1c00_003c, 1'b0);
    tick();
    set_commit(32'h1c00_0040, 1'b1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_commit(32'h1c00_0100 + 32'(4 * i), 1'b0);
      check($sformatf("t4_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t4_pc%0d", i), out_pc, 32'h1c00_0038 + 32'(4 * i));
      check($sformatf("t4_halt%0d", i), 32'(out_halt), (i == 2) ? 32'd1 : 32'd0);
      check($sformatf("t4_done%0d", i), 32'(done), 32'd0);
      tick();
    end
    ticks_at_done = ticks;
    check("t4_done", 32'(done), 32'd1);
    check("t4_empty", 32'(out_valid), 32'd0);
    check("t4_cycle_at_done", cycle_cnt, 32'(ticks_at_done));
    set_commit(32'h1c00_010c, 1'b0);
    tick();
    idle();
    tick();
    tick();
    check("t4_done_sticky", 32'(done), 32'd1);
    check("t4_cycle_frozen", cycle_cnt, 32'(ticks_at_done));
    check("t4_commit_cnt", commit_cnt, 32'd23);
    check("t4_drop_cnt", drop_cnt, 32'd2);
    check("t4_still_empty", 32'(out_valid), 32'd0);

    // 5: asynchronous reset in DRAIN with five entries queued
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    ticks = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_commit(32'h1c00_3000 + 32'(4 * i), i == 4);
      tick();
    end
    idle();
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    check("t5_pre_commit_cnt", commit_cnt, 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_done", 32'(done), 32'd0);
    check("t5_async_commit_cnt", commit_cnt, 32'd0);
    check("t5_async_cycle_cnt", cycle_cnt, 32'd0);
    check("t5_async_drop_cnt", drop_cnt, 32'd0);
    check("t5_async_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ticks = 0;
    out_ready = 1'b1;
    set_commit(32'h1c00_4000, 1'b0);
    tick();
    idle();
    check("t5_new_valid", 32'(out_valid), 32'd1);
    check("t5_new_pc", out_pc, 32'h1c00_4000);
    check("t5_new_commit_cnt", commit_cnt, 32'd1);
    tick();
    check("t5_new_drained", 32'(out_valid), 32'd0);

    // 6: head record held stable under back-pressure
    out_ready = 1'b0;
    set_commit(32'h1c00_5004, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t6_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t6_pc%0d", i), out_pc, 32'h1c00_5004);
      check($sformatf("t6_instr%0d", i), out_instr, 32'he3ff_affb);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t6_drained", 32'(out_valid), 32'd0);
    check("t6_commit_cnt", commit_cnt, 32'd2);
    check("t6_cycle_cnt", cycle_cnt, 32'(ticks));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
